// File: rtl/capture_ctrl.sv
// capture_ctrl: frame capture sequencer for a camera-to-frame-buffer path.
// Arms on a host start request, waits for the next VSYNC falling edge, gates
// pixel writes into the frame buffer while the frame is active, and judges the
// frame on the VSYNC rising edge (complete, short, overflowed). A per-state
// timeout catches a stalled camera. Optional continuous mode re-arms after
// every good frame.
//
// Ports
//   clk_i          camera pixel clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle capture request (honoured only in IDLE)
//   release_i      host consumed frame/error; aborts ARM/CAPTURE to IDLE
//   cont_i         continuous mode: DONE re-arms instead of waiting
//   cam_vsync_i    camera VSYNC, high during blanking
//   wr_req_i       pixel write strobe from the capture block
//   wr_addr_i      pixel write address
//   wr_en_o        gated frame-buffer write enable (combinational)
//   busy_o         high in ARM or CAPTURE
//   done_o         frame complete and valid
//   err_o          00 none, 01 short frame, 10 overflow, 11 timeout
//   px_cnt_o       pixels written in the current or last frame
//   frame_cnt_o    successful frame count, wraps at 255
//
// state   | meaning
// IDLE    | waiting for start
// ARM     | waiting for VSYNC fall (start of a fresh frame)
// CAPTURE | frame active, writes gated into the buffer
// DONE    | good frame in buffer
// ERROR   | frame failed, err_o held until release
module capture_ctrl #(
    parameter int AW        = 15,
    parameter int PIX_TOTAL = 19200,
    parameter int TO_CYC    = 2000000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          release_i,
    input  logic          cont_i,
    input  logic          cam_vsync_i,
    input  logic          wr_req_i,
    input  logic [AW-1:0] wr_addr_i,
    output logic          wr_en_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    err_o,
    output logic [AW-1:0] px_cnt_o,
    output logic [7:0]    frame_cnt_o
);

    localparam int            TW       = $clog2(TO_CYC + 1);
    localparam logic [AW-1:0] PIX_END  = AW'(PIX_TOTAL);
    localparam logic [TW-1:0] TMR_LAST = TW'(TO_CYC - 1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic          vsync_q;
    logic [AW-1:0] px_cnt_q, px_cnt_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [1:0]    err_q, err_d, err_set;
    logic          ovf_q, ovf_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          fall, rise, tmo, addr_ok, room, wr_en;

    assign fall    = vsync_q & ~cam_vsync_i;
    assign rise    = ~vsync_q & cam_vsync_i;
    // this cycle is the TO_CYC-th spent in the current state
    assign tmo     = (tmr_q == TMR_LAST);
    assign addr_ok = (wr_addr_i < PIX_END);
    assign room    = (px_cnt_q < PIX_END);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        err_set = ERR_NONE;
        case (state_q)
            S_IDLE: begin
                if (start_i && !release_i) state_d = S_ARM;
            end
            S_ARM: begin
                if (release_i)  state_d = S_IDLE;
                else if (fall)  state_d = S_CAPTURE;
                else if (tmo) begin
                    state_d = S_ERROR;
                    err_set = ERR_TMO;
                end
            end
            S_CAPTURE: begin
                if (release_i) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    if (ovf_q) begin
                        state_d = S_ERROR;
                        err_set = ERR_OVF;
                    end else if (px_cnt_q != PIX_END) begin
                        state_d = S_ERROR;
                        err_set = ERR_SHORT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (tmo) begin
                    state_d = S_ERROR;
                    err_set = ERR_TMO;
                end
            end
            S_DONE: begin
                if (release_i)   state_d = S_IDLE;
                else if (cont_i) state_d = S_ARM;
            end
            S_ERROR: begin
                if (release_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en  = 1'b0;
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_ARM:     busy_o = 1'b1;
            S_CAPTURE: begin
                busy_o = 1'b1;
                // release kills the write in the abort cycle itself
                wr_en  = wr_req_i & ~release_i & addr_ok & room;
            end
            S_DONE:    done_o = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        px_cnt_d    = px_cnt_q;
        ovf_d       = ovf_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        if (state_d != state_q) tmr_d = '0;
        else if (busy_o)        tmr_d = tmr_q + TW'(1);
        else                    tmr_d = tmr_q;

        if (state_q == S_ARM && state_d == S_CAPTURE) begin
            px_cnt_d = '0;
            ovf_d    = 1'b0;
        end
        if (wr_en) px_cnt_d = px_cnt_q + AW'(1);
        if (state_q == S_CAPTURE && wr_req_i && (!addr_ok || !room)) ovf_d = 1'b1;
        if (state_q == S_CAPTURE && state_d == S_DONE) frame_cnt_d = frame_cnt_q + 8'd1;

        if (state_d == S_ERROR && state_q != S_ERROR)      err_d = err_set;
        else if (state_q == S_ERROR && state_d == S_IDLE)  err_d = ERR_NONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsync_q     <= 1'b1;
            px_cnt_q    <= '0;
            frame_cnt_q <= '0;
            err_q       <= ERR_NONE;
            ovf_q       <= 1'b0;
            tmr_q       <= '0;
        end else begin
            vsync_q     <= cam_vsync_i;
            px_cnt_q    <= px_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            tmr_q       <= tmr_d;
        end
    end

    assign wr_en_o     = wr_en;
    assign err_o       = err_q;
    assign px_cnt_o    = px_cnt_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed scenarios plus randomized frames for capture_ctrl,
// every cycle compared against a behavioural model of the capture rules.
module tb_capture_ctrl;

    localparam int AW  = 5;
    localparam int PIX = 16;
    localparam int TOC = 100;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_CAP  = 2;
    localparam int M_DONE = 3;
    localparam int M_ERR  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rel = 1'b0;
    logic          cont = 1'b0;
    logic          vsync = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_en, busy, done;
    logic [1:0]    err;
    logic [AW-1:0] px_cnt;
    logic [7:0]    frame_cnt;

    int n_checks = 0;
    int n_errs   = 0;
    int wr_seen  = 0;
    int done_seen = 0;

    int m_st, m_vs, m_px, m_frames, m_err, m_ovf, m_age;

    always #5 clk = ~clk;

    capture_ctrl #(.AW(AW), .PIX_TOTAL(PIX), .TO_CYC(TOC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .release_i(rel),
        .cont_i(cont), .cam_vsync_i(vsync), .wr_req_i(wr_req), .wr_addr_i(wr_addr),
        .wr_en_o(wr_en), .busy_o(busy), .done_o(done), .err_o(err),
        .px_cnt_o(px_cnt), .frame_cnt_o(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_vs = 1; m_px = 0; m_frames = 0;
        m_err = 0; m_ovf = 0; m_age = 0;
    endtask

    function automatic int model_wr();
        return ((m_st == M_CAP) && wr_req && !rel && (wr_addr < PIX) && (m_px < PIX)) ? 1 : 0;
    endfunction

    task automatic model_step();
        int  nst;
        bit  fall, rise, w, bad;
        fall = (m_vs == 1) && !vsync;
        rise = (m_vs == 0) && vsync;
        w    = (model_wr() == 1);
        bad  = (m_st == M_CAP) && wr_req && ((wr_addr >= PIX) || (m_px >= PIX));
        nst  = m_st;
        case (m_st)
            M_IDLE: if (start && !rel) nst = M_ARM;
            M_ARM: begin
                if (rel) nst = M_IDLE;
                else if (fall) nst = M_CAP;
                else if (m_age + 1 >= TOC) begin nst = M_ERR; m_err = 3; end
            end
            M_CAP: begin
                if (rel) nst = M_IDLE;
                else if (rise) begin
                    if (m_ovf != 0)      begin nst = M_ERR; m_err = 2; end
                    else if (m_px != PIX) begin nst = M_ERR; m_err = 1; end
                    else begin nst = M_DONE; m_frames = (m_frames + 1) % 256; end
                end else if (m_age + 1 >= TOC) begin nst = M_ERR; m_err = 3; end
            end
            M_DONE: begin
                if (rel) nst = M_IDLE;
                else if (cont) nst = M_ARM;
            end
            default: if (rel) begin nst = M_IDLE; m_err = 0; end
        endcase
        if (m_st == M_ARM && nst == M_CAP) begin m_px = 0; m_ovf = 0; end
        if (w) m_px++;
        if (bad) m_ovf = 1;
        m_age = (nst != m_st) ? 0 : m_age + 1;
        m_st  = nst;
        m_vs  = vsync ? 1 : 0;
    endtask

    task automatic tick();
        @(negedge clk);
        chk("wr_en", wr_en, model_wr());
        chk("busy", busy, (m_st == M_ARM || m_st == M_CAP) ? 1 : 0);
        chk("done", done, (m_st == M_DONE) ? 1 : 0);
        chk("err", err, m_err);
        chk("px_cnt", px_cnt, m_px);
        chk("frame_cnt", frame_cnt, m_frames);
        if (wr_en) wr_seen++;
        if (done) done_seen++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; rel = 0; vsync = 1; wr_req = 0; wr_addr = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic pulse_release();
        rel = 1; tick(); rel = 0;
    endtask

    // vsync low for the frame, nw write strobes (random gaps), then vsync high
    task automatic send_frame(input int nw, input int bad_at);
        vsync = 0; wr_req = 0; tick();
        for (int k = 0; k < nw; k++) begin
            if ($urandom_range(0, 3) == 0) begin wr_req = 0; tick(); end
            wr_req  = 1;
            wr_addr = (k == bad_at) ? AW'(PIX + $urandom_range(0, 15)) : AW'(k % PIX);
            tick();
        end
        wr_req = 0; vsync = 1; tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_px", px_cnt, 0);
        chk("rst_frames", frame_cnt, 0);
        rst_n = 1;

        // continuous mode alone must not leave IDLE after reset
        cont = 1; repeat (3) tick();
        chk("idle_after_rst", busy, 0);
        cont = 0;

        // nominal frame
        pulse_start(); tick();
        wr_seen = 0;
        send_frame(16, -1);
        chk("nom_done", done, 1);
        chk("nom_px", px_cnt, 16);
        chk("nom_frames", frame_cnt, 1);
        chk("nom_err", err, 0);
        chk("nom_wr_cycles", wr_seen, 16);
        tick();
        chk("nom_done_hold", done, 1);
        pulse_release();
        chk("nom_rel_idle", done, 0);

        // short frame
        pulse_start(); tick();
        send_frame(10, -1);
        chk("short_err", err, 1);
        chk("short_px", px_cnt, 10);
        pulse_release();
        chk("short_err_clr", err, 0);

        // overflow by count
        pulse_start(); tick();
        wr_seen = 0;
        send_frame(17, -1);
        chk("ovf_cnt_err", err, 2);
        chk("ovf_cnt_wr", wr_seen, 16);
        chk("ovf_cnt_px", px_cnt, 16);
        pulse_release();

        // overflow by out-of-range address
        pulse_start(); tick();
        send_frame(16, 5);
        chk("ovf_addr_err", err, 2);
        chk("ovf_addr_px", px_cnt, 15);
        pulse_release();

        // timeout in ARM
        pulse_start();
        vsync = 1;
        repeat (TOC - 1) tick();
        chk("tmo_busy_before", busy, 1);
        tick();
        chk("tmo_err", err, 3);
        chk("tmo_busy", busy, 0);
        pulse_release();

        // continuous mode, three frames, then start+release in DONE
        do_reset();
        cont = 1;
        pulse_start(); tick();
        done_seen = 0;
        for (int f = 0; f < 3; f++) begin
            send_frame(16, -1);
            if (f < 2) tick();
        end
        start = 1; rel = 1; tick(); start = 0; rel = 0;
        chk("cont_frames", frame_cnt, 3);
        chk("cont_done_pulses", done_seen, 3);
        chk("cont_idle_busy", busy, 0);
        chk("cont_idle_done", done, 0);
        tick();
        chk("cont_stay_idle", busy, 0);
        cont = 0;

        // reset asserted on the 8th write
        do_reset();
        pulse_start(); tick();
        vsync = 0; tick();
        for (int k = 0; k < 7; k++) begin
            wr_req = 1; wr_addr = AW'(k); tick();
        end
        wr_req = 1; wr_addr = AW'(7);
        #2;
        chk("rst8_wr_before", wr_en, 1);
        rst_n = 0;
        #1;
        chk("rst8_wr_en", wr_en, 0);
        chk("rst8_busy", busy, 0);
        chk("rst8_done", done, 0);
        chk("rst8_err", err, 0);
        chk("rst8_px", px_cnt, 0);
        chk("rst8_frames", frame_cnt, 0);
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        pulse_start(); tick();
        send_frame(16, -1);
        chk("rst8_after_done", done, 1);
        chk("rst8_after_px", px_cnt, 16);
        chk("rst8_after_frames", frame_cnt, 1);
        pulse_release();

        // randomized frames with random start/release/cont
        for (int it = 0; it < 60; it++) begin
            int nw, bad;
            cont = $urandom_range(0, 1);
            if ($urandom_range(0, 2) != 0) pulse_start();
            repeat ($urandom_range(1, 6)) begin
                rel = ($urandom_range(0, 9) == 0);
                tick();
            end
            rel = 0;
            nw  = ($urandom_range(0, 1) == 0) ? 16 : $urandom_range(8, 18);
            bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nw - 1) : -1;
            send_frame(nw, bad);
            repeat ($urandom_range(1, 3)) begin
                rel = ($urandom_range(0, 3) == 0);
                tick();
            end
            rel = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
